ahb_master_arbiter: RTL and testbench

//   Two-master AHB-Lite arbiter between the SPI loader and the RISC-V core, feeding the single

---
 rtl/ahb_master_arbiter.sv | 138 +++++++++++++
 tb/tb_ahb_master_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: two-master AHB-Lite arbiter (SPI loader, RISC-V core) onto one shared slave port
module ahb_master_arbiter #(
    parameter int ARB_MODE = 0,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] spi_haddr,
    input  logic [1:0]        spi_htrans,
    input  logic              spi_hwrite,
    input  logic [2:0]        spi_hsize,
    input  logic [2:0]        spi_hburst,
    input  logic [3:0]        spi_hprot,
    input  logic              spi_hmastlock,
    input  logic [DATA_W-1:0] spi_hwdata,
    output logic [DATA_W-1:0] spi_hrdata,
    output logic              spi_hready,
    output logic              spi_hresp,
    input  logic [ADDR_W-1:0] core_haddr,
    input  logic [1:0]        core_htrans,
    input  logic              core_hwrite,
    input  logic [2:0]        core_hsize,
    input  logic [2:0]        core_hburst,
    input  logic [3:0]        core_hprot,
    input  logic              core_hmastlock,
    input  logic [DATA_W-1:0] core_hwdata,
    output logic [DATA_W-1:0] core_hrdata,
    output logic              core_hready,
    output logic              core_hresp,
    output logic [ADDR_W-1:0] slv_haddr,
    output logic [1:0]        slv_htrans,
    output logic              slv_hwrite,
    output logic [2:0]        slv_hsize,
    output logic [2:0]        slv_hburst,
    output logic [3:0]        slv_hprot,
    output logic              slv_hmastlock,
    output logic [DATA_W-1:0] slv_hwdata,
    input  logic [DATA_W-1:0] slv_hrdata,
    input  logic              slv_hready,
    input  logic              slv_hresp
);
    // ctl layout: [13:12] htrans, [11] hwrite, [10:8] hsize, [7:5] hburst, [4:1] hprot, [0] hmastlock
    localparam int CW = 14;
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;

    logic [1:0][ADDR_W-1:0] live_addr, held_addr_q, held_addr_d, eff_addr;
    logic [1:0][CW-1:0]     live_ctl, held_ctl_q, held_ctl_d, eff_ctl;
    logic [1:0]             held_v_q, held_v_d, req, m_hready, cap;
    logic                   own_q, own_d, lock_q, lock_d, dp_v_q, dp_v_d, dp_own_q, dp_own_d;
    logic                   rr_last_q, rr_last_d, frz_q, frz_d, sel_q, sel_d;
    logic                   sel, arb, keep;
    logic [1:0]             own_trans, sel_trans;
    logic [CW-1:0]          sel_ctl;

    assign live_addr = {core_haddr, spi_haddr};
    assign live_ctl  = {{core_htrans, core_hwrite, core_hsize, core_hburst, core_hprot, core_hmastlock},
                        {spi_htrans, spi_hwrite, spi_hsize, spi_hburst, spi_hprot, spi_hmastlock}};

    always_comb begin
        for (int m = 0; m < 2; m++) begin
            eff_addr[m] = held_v_q[m] ? held_addr_q[m] : live_addr[m];
            eff_ctl[m]  = held_v_q[m] ? held_ctl_q[m] : live_ctl[m];
            req[m]      = eff_ctl[m][13];
            m_hready[m] = (dp_v_q && dp_own_q == 1'(m)) ? slv_hready : !held_v_q[m];
        end
    end

    // Bursts and locked sequences keep the current owner; a wait state freezes the previous pick.
    always_comb begin
        own_trans = eff_ctl[own_q][13:12];
        keep      = own_trans == SEQ || own_trans == BUSY || lock_q;
        arb       = (req == 2'b11) ? ((ARB_MODE != 0) ? !rr_last_q : 1'b0) :
                    (req == 2'b10) ? 1'b1 : (req == 2'b01) ? 1'b0 : own_q;
        sel       = frz_q ? sel_q : keep ? own_q : arb;
    end

    always_comb begin
        sel_ctl       = eff_ctl[sel];
        sel_trans     = sel_ctl[13:12];
        slv_haddr     = eff_addr[sel];
        slv_htrans    = rst ? IDLE : sel_trans;
        slv_hwrite    = sel_ctl[11];
        slv_hsize     = sel_ctl[10:8];
        slv_hburst    = sel_ctl[7:5];
        slv_hprot     = sel_ctl[4:1];
        slv_hmastlock = sel_ctl[0];
        slv_hwdata    = dp_own_q ? core_hwdata : spi_hwdata;
        spi_hrdata    = slv_hrdata;
        core_hrdata   = slv_hrdata;
        spi_hready    = m_hready[0];
        core_hready   = m_hready[1];
        spi_hresp     = dp_v_q && !dp_own_q && slv_hresp;
        core_hresp    = dp_v_q && dp_own_q && slv_hresp;
    end

    always_comb begin
        own_d     = slv_hready ? sel : own_q;
        dp_v_d    = slv_hready ? sel_trans[1] : dp_v_q;
        dp_own_d  = slv_hready ? sel : dp_own_q;
        lock_d    = !slv_hready ? lock_q : (sel_trans != IDLE) ? sel_ctl[0] : lock_q && sel_ctl[0];
        rr_last_d = (slv_hready && sel_trans == NONSEQ) ? sel : rr_last_q;
        frz_d     = !slv_hready;
        sel_d     = sel;
        for (int m = 0; m < 2; m++) begin
            cap[m]         = live_ctl[m][13] && m_hready[m] && !(sel == 1'(m) && slv_hready);
            held_v_d[m]    = (sel == 1'(m) && slv_hready) ? 1'b0 : cap[m] ? 1'b1 : held_v_q[m];
            held_addr_d[m] = cap[m] ? live_addr[m] : held_addr_q[m];
            held_ctl_d[m]  = cap[m] ? live_ctl[m] : held_ctl_q[m];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_v_q    <= '0;
            held_addr_q <= '0;
            held_ctl_q  <= '0;
            own_q       <= 1'b0;
            lock_q      <= 1'b0;
            dp_v_q      <= 1'b0;
            dp_own_q    <= 1'b0;
            rr_last_q   <= 1'b1;
            frz_q       <= 1'b0;
            sel_q       <= 1'b0;
        end else begin
            held_v_q    <= held_v_d;
            held_addr_q <= held_addr_d;
            held_ctl_q  <= held_ctl_d;
            own_q       <= own_d;
            lock_q      <= lock_d;
            dp_v_q      <= dp_v_d;
            dp_own_q    <= dp_own_d;
            rr_last_q   <= rr_last_d;
            frz_q       <= frz_d;
            sel_q       <= sel_d;
        end
    end
endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb_ahb_master_arbiter: directed checks of a fixed-priority (dut 0) and a round-robin (dut 1) arbiter
module tb_ahb_master_arbiter;
    logic clk, rst;
    logic [31:0] spi_haddr, core_haddr, spi_hwdata, core_hwdata, slv_hrdata;
    logic [1:0]  spi_htrans, core_htrans;
    logic        spi_hwrite, core_hwrite, spi_hmastlock, core_hmastlock, slv_hready, slv_hresp;
    logic [2:0]  spi_hsize, core_hsize, spi_hburst, core_hburst;
    logic [3:0]  spi_hprot, core_hprot;
    logic [1:0][31:0] spi_hrdata, core_hrdata, slv_haddr, slv_hwdata;
    logic [1:0][1:0]  slv_htrans;
    logic [1:0][2:0]  slv_hsize, slv_hburst;
    logic [1:0][3:0]  slv_hprot;
    logic [1:0]       spi_hready, spi_hresp, core_hready, core_hresp, slv_hwrite, slv_hmastlock;
    int vec = 0;
    int errs = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ahb_master_arbiter #(.ARB_MODE(g), .ADDR_W(32), .DATA_W(32)) dut (
            .clk(clk), .rst(rst),
            .spi_haddr(spi_haddr), .spi_htrans(spi_htrans), .spi_hwrite(spi_hwrite),
            .spi_hsize(spi_hsize), .spi_hburst(spi_hburst), .spi_hprot(spi_hprot),
            .spi_hmastlock(spi_hmastlock), .spi_hwdata(spi_hwdata),
            .spi_hrdata(spi_hrdata[g]), .spi_hready(spi_hready[g]), .spi_hresp(spi_hresp[g]),
            .core_haddr(core_haddr), .core_htrans(core_htrans), .core_hwrite(core_hwrite),
            .core_hsize(core_hsize), .core_hburst(core_hburst), .core_hprot(core_hprot),
            .core_hmastlock(core_hmastlock), .core_hwdata(core_hwdata),
            .core_hrdata(core_hrdata[g]), .core_hready(core_hready[g]), .core_hresp(core_hresp[g]),
            .slv_haddr(slv_haddr[g]), .slv_htrans(slv_htrans[g]), .slv_hwrite(slv_hwrite[g]),
            .slv_hsize(slv_hsize[g]), .slv_hburst(slv_hburst[g]), .slv_hprot(slv_hprot[g]),
            .slv_hmastlock(slv_hmastlock[g]), .slv_hwdata(slv_hwdata[g]),
            .slv_hrdata(slv_hrdata), .slv_hready(slv_hready), .slv_hresp(slv_hresp)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_spi(input logic [1:0] t, input logic [31:0] a, input logic w, input logic l);
        spi_htrans = t; spi_haddr = a; spi_hwrite = w; spi_hmastlock = l;
    endtask

    task automatic set_core(input logic [1:0] t, input logic [31:0] a, input logic w, input logic l,
                            input logic [2:0] b);
        core_htrans = t; core_haddr = a; core_hwrite = w; core_hmastlock = l; core_hburst = b;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        set_spi(2'd0, 32'h0, 1'b0, 1'b0);
        set_core(2'd0, 32'h0, 1'b0, 1'b0, 3'd0);
        slv_hready = 1'b1; slv_hresp = 1'b0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_spi(2'd2, 32'h123, 1'b1, 1'b1);
        set_core(2'd2, 32'h456, 1'b0, 1'b0, 3'd0);
        slv_hready = 1'b0; slv_hresp = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            vec++; if (slv_htrans[d] !== 2'd0) begin errs++; $display("FAIL rst_htrans dut%0d got %0d want 0", d, slv_htrans[d]); end
            vec++; if (spi_hready[d] !== 1'b1) begin errs++; $display("FAIL rst_spi_hready dut%0d got %b want 1", d, spi_hready[d]); end
            vec++; if (core_hready[d] !== 1'b1) begin errs++; $display("FAIL rst_core_hready dut%0d got %b want 1", d, core_hready[d]); end
            vec++; if (spi_hresp[d] !== 1'b0) begin errs++; $display("FAIL rst_spi_hresp dut%0d got %b want 0", d, spi_hresp[d]); end
            vec++; if (core_hresp[d] !== 1'b0) begin errs++; $display("FAIL rst_core_hresp dut%0d got %b want 0", d, core_hresp[d]); end
        end
        do_reset();
    endtask

    task automatic test_single;
        do_reset();
        set_spi(2'd2, 32'h100, 1'b1, 1'b0);
        spi_hsize = 3'd2; spi_hprot = 4'h3; spi_hburst = 3'd0;
        slv_hrdata = 32'hDEAD_BEEF;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            vec++; if (slv_haddr[d] !== 32'h100) begin errs++; $display("FAIL t1_haddr dut%0d got %h want 00000100", d, slv_haddr[d]); end
            vec++; if (slv_htrans[d] !== 2'd2) begin errs++; $display("FAIL t1_htrans dut%0d got %0d want 2", d, slv_htrans[d]); end
            vec++; if ({slv_hwrite[d], slv_hsize[d], slv_hburst[d], slv_hprot[d], slv_hmastlock[d]} !== {1'b1, 3'd2, 3'd0, 4'h3, 1'b0})
                begin errs++; $display("FAIL t1_ctrl dut%0d got %b%h%h%h%b want 1200 30", d, slv_hwrite[d], slv_hsize[d], slv_hburst[d], slv_hprot[d], slv_hmastlock[d]); end
            vec++; if (core_hready[d] !== 1'b1) begin errs++; $display("FAIL t1_core_hready dut%0d got %b want 1", d, core_hready[d]); end
            vec++; if (spi_hrdata[d] !== 32'hDEAD_BEEF || core_hrdata[d] !== 32'hDEAD_BEEF)
                begin errs++; $display("FAIL t1_hrdata dut%0d got %h/%h want deadbeef", d, spi_hrdata[d], core_hrdata[d]); end
        end
        next_cycle();
        set_spi(2'd0, 32'h0, 1'b0, 1'b0);
        spi_hwdata = 32'hA5A5; slv_hready = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            vec++; if (slv_hwdata[d] !== 32'hA5A5) begin errs++; $display("FAIL t1_hwdata dut%0d got %h want 0000a5a5", d, slv_hwdata[d]); end
            vec++; if (spi_hready[d] !== 1'b0) begin errs++; $display("FAIL t1_spi_wait dut%0d got %b want 0", d, spi_hready[d]); end
            vec++; if (core_hready[d] !== 1'b1) begin errs++; $display("FAIL t1_core_free dut%0d got %b want 1", d, core_hready[d]); end
        end
        next_cycle();
        slv_hready = 1'b1;
        @(negedge clk);
        vec++; if (spi_hready[0] !== 1'b1) begin errs++; $display("FAIL t1_spi_done got %b want 1", spi_hready[0]); end
        next_cycle();
    endtask

    task automatic test_contention;
        do_reset();
        set_spi(2'd2, 32'h200, 1'b1, 1'b0);
        set_core(2'd2, 32'h300, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        vec++; if (slv_haddr[0] !== 32'h200) begin errs++; $display("FAIL t2_first got %h want 00000200", slv_haddr[0]); end
        vec++; if (core_hready[0] !== 1'b1) begin errs++; $display("FAIL t2_core_cap got %b want 1", core_hready[0]); end
        next_cycle();
        set_spi(2'd0, 32'h0, 1'b0, 1'b0);
        set_core(2'd0, 32'h0, 1'b0, 1'b0, 3'd0);
        spi_hwdata = 32'h11;
        @(negedge clk);
        vec++; if (slv_haddr[0] !== 32'h300 || slv_htrans[0] !== 2'd2 || slv_hwrite[0] !== 1'b0)
            begin errs++; $display("FAIL t2_replay got %h/%0d/%b want 00000300/2/0", slv_haddr[0], slv_htrans[0], slv_hwrite[0]); end
        vec++; if (core_hready[0] !== 1'b0) begin errs++; $display("FAIL t2_core_stall got %b want 0", core_hready[0]); end
        vec++; if (spi_hready[0] !== 1'b1) begin errs++; $display("FAIL t2_spi_rdy got %b want 1", spi_hready[0]); end
        vec++; if (slv_hwdata[0] !== 32'h11) begin errs++; $display("FAIL t2_hwdata got %h want 00000011", slv_hwdata[0]); end
        next_cycle();
        slv_hready = 1'b0; slv_hresp = 1'b1;
        @(negedge clk);
        vec++; if ({core_hready[0], core_hresp[0], spi_hresp[0]} !== 3'b010)
            begin errs++; $display("FAIL t2_err1 got rdy/resp/spiresp %b want 010", {core_hready[0], core_hresp[0], spi_hresp[0]}); end
        next_cycle();
        slv_hready = 1'b1;
        @(negedge clk);
        vec++; if ({core_hready[0], core_hresp[0], spi_hresp[0]} !== 3'b110)
            begin errs++; $display("FAIL t2_err2 got rdy/resp/spiresp %b want 110", {core_hready[0], core_hresp[0], spi_hresp[0]}); end
        next_cycle();
        slv_hresp = 1'b0;
    endtask

    task automatic test_burst;
        logic [31:0] exp_a [5] = '{32'h1008, 32'h100C, 32'h40, 32'h0, 32'h0};
        logic        exp_r [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        set_core(2'd2, 32'h1000, 1'b0, 1'b0, 3'd3);
        @(negedge clk);
        vec++; if (slv_haddr[0] !== 32'h1000) begin errs++; $display("FAIL t3_beat1 got %h want 00001000", slv_haddr[0]); end
        next_cycle();
        set_core(2'd3, 32'h1004, 1'b0, 1'b0, 3'd3);
        set_spi(2'd2, 32'h40, 1'b1, 1'b0);
        @(negedge clk);
        vec++; if (slv_haddr[0] !== 32'h1004 || slv_htrans[0] !== 2'd3 || slv_hburst[0] !== 3'd3)
            begin errs++; $display("FAIL t3_beat2 got %h/%0d/%0d want 00001004/3/3", slv_haddr[0], slv_htrans[0], slv_hburst[0]); end
        vec++; if (spi_hready[0] !== 1'b1) begin errs++; $display("FAIL t3_spi_cap got %b want 1", spi_hready[0]); end
        next_cycle();
        set_spi(2'd0, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k == 0) set_core(2'd3, 32'h1008, 1'b0, 1'b0, 3'd3);
            if (k == 1) set_core(2'd3, 32'h100C, 1'b0, 1'b0, 3'd3);
            if (k == 2) set_core(2'd0, 32'h0, 1'b0, 1'b0, 3'd0);
            @(negedge clk);
            if (k < 3) begin
                vec++; if (slv_haddr[0] !== exp_a[k]) begin errs++; $display("FAIL t3_addr%0d got %h want %h", k, slv_haddr[0], exp_a[k]); end
            end
            vec++; if (spi_hready[0] !== exp_r[k]) begin errs++; $display("FAIL t3_spi_rdy%0d got %b want %b", k, spi_hready[0], exp_r[k]); end
            next_cycle();
        end
    endtask

    task automatic test_round_robin;
        logic [31:0] exp_a [6] = '{32'h10, 32'h20, 32'h14, 32'h24, 32'h18, 32'h28};
        int si = 0;
        int ci = 0;
        logic rs, rc;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            set_spi(2'd2, 32'h10 + 32'(4 * si), 1'b1, 1'b0);
            set_core(2'd2, 32'h20 + 32'(4 * ci), 1'b0, 1'b0, 3'd0);
            @(negedge clk);
            vec++; if (slv_haddr[1] !== exp_a[k]) begin errs++; $display("FAIL t4_order%0d got %h want %h", k, slv_haddr[1], exp_a[k]); end
            rs = spi_hready[1];
            rc = core_hready[1];
            next_cycle();
            if (rs) si++;
            if (rc) ci++;
        end
        set_spi(2'd0, 32'h0, 1'b0, 1'b0);
        set_core(2'd0, 32'h0, 1'b0, 1'b0, 3'd0);
        next_cycle();
        next_cycle();
    endtask

    task automatic test_lock;
        logic [31:0] exp_a [4] = '{32'h504, 32'h508, 32'h50C, 32'h60};
        logic        exp_r [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        set_core(2'd2, 32'h500, 1'b0, 1'b1, 3'd0);
        @(negedge clk);
        vec++; if (slv_hmastlock[0] !== 1'b1) begin errs++; $display("FAIL t5_lock got %b want 1", slv_hmastlock[0]); end
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin set_core(2'd2, 32'h504, 1'b0, 1'b1, 3'd0); set_spi(2'd2, 32'h60, 1'b1, 1'b0); end
            if (k == 1) begin set_core(2'd2, 32'h508, 1'b0, 1'b1, 3'd0); set_spi(2'd0, 32'h0, 1'b0, 1'b0); end
            if (k == 2) set_core(2'd2, 32'h50C, 1'b0, 1'b0, 3'd0);
            if (k == 3) set_core(2'd0, 32'h0, 1'b0, 1'b0, 3'd0);
            @(negedge clk);
            vec++; if (slv_haddr[0] !== exp_a[k]) begin errs++; $display("FAIL t5_addr%0d got %h want %h", k, slv_haddr[0], exp_a[k]); end
            vec++; if (spi_hready[0] !== exp_r[k]) begin errs++; $display("FAIL t5_spi_rdy%0d got %b want %b", k, spi_hready[0], exp_r[k]); end
            next_cycle();
        end
        next_cycle();
    endtask

    task automatic test_async_reset;
        do_reset();
        set_core(2'd2, 32'h700, 1'b0, 1'b0, 3'd0);
        next_cycle();
        set_core(2'd0, 32'h0, 1'b0, 1'b0, 3'd0);
        set_spi(2'd2, 32'h80, 1'b1, 1'b0);
        slv_hready = 1'b0;
        next_cycle();
        set_spi(2'd0, 32'h0, 1'b0, 1'b0);
        #2;
        vec++; if (spi_hready[0] !== 1'b0 || slv_htrans[0] !== 2'd2 || slv_haddr[0] !== 32'h80)
            begin errs++; $display("FAIL t6_held got rdy %b trans %0d addr %h want 0/2/00000080", spi_hready[0], slv_htrans[0], slv_haddr[0]); end
        rst = 1'b1;
        #1;
        vec++; if (slv_htrans[0] !== 2'd0) begin errs++; $display("FAIL t6_rst_trans got %0d want 0", slv_htrans[0]); end
        vec++; if (spi_hready[0] !== 1'b1 || core_hready[0] !== 1'b1)
            begin errs++; $display("FAIL t6_rst_rdy got %b/%b want 1/1", spi_hready[0], core_hready[0]); end
        next_cycle();
        rst = 1'b0;
        slv_hready = 1'b1;
        @(negedge clk);
        vec++; if (slv_htrans[0] !== 2'd0 || spi_hready[0] !== 1'b1)
            begin errs++; $display("FAIL t6_dropped got trans %0d rdy %b want 0/1", slv_htrans[0], spi_hready[0]); end
        next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        spi_hwdata = '0; core_hwdata = '0; slv_hrdata = '0;
        spi_hsize = '0; spi_hburst = '0; spi_hprot = '0;
        core_hsize = '0; core_hprot = '0;
        test_reset();
        test_single();
        test_contention();
        test_burst();
        test_round_robin();
        test_lock();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
